result_bcd_converter: RTL and testbench
=======================================

RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

Interface
REQ-001 Parameter BITS, default 21, SHALL set the width of the signed binary input (ALU result width).
REQ-002 Parameter DIGITS, default 6, SHALL set the number of BCD output digits.
REQ-003 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 start  input  1  SHALL request a conversion of value; it is sampled only in IDLE.
REQ-006 value  input  BITS  SHALL carry the signed two's-complement ALU result.
REQ-007 ovf_in  input  1  SHALL carry the ALU overflow flag; it is sampled with value.
REQ-008 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-009 done  output  1  SHALL be a one-cycle pulse marking valid digits/negative/error.
REQ-010 digits  output  4*DIGITS  SHALL hold the BCD magnitude, most significant digit in the top nibble.
REQ-011 negative  output  1  SHALL be high when the converted value was negative.
REQ-012 error  output  1  SHALL be high when ovf_in was set or |value| > 10^DIGITS-1.

Function
REQ-013 States SHALL be IDLE, SHIFT and DONE only.
REQ-014 In IDLE with start=1, the block SHALL capture negative=value[BITS-1], capture magnitude=|value| as an unsigned BITS-bit number (so -2^(BITS-1) is represented exactly), capture ovf_in, clear the BCD accumulator and bit counter, and enter SHIFT.
REQ-015 The BCD accumulator SHALL be DIGITS+1 digits wide so that any BITS=21 magnitude (maximum 1048576) fits.
REQ-016 Each SHIFT cycle SHALL add 3 to every accumulator digit >= 5, then shift {accumulator, magnitude} left by one bit; this is the double-dabble algorithm.
REQ-017 SHIFT SHALL last exactly BITS cycles, then enter DONE.
REQ-018 In DONE, the block SHALL register the outputs, pulse done for one cycle and return to IDLE. done SHALL be high in the cycle beginning BITS+2 edges after the edge that sampled start (23 for BITS=21).
REQ-019 error SHALL be set if the captured ovf_in is 1 or the extra top accumulator digit is non-zero. When error=1, digits SHALL be all zero.
REQ-020 digits, negative and error SHALL hold their values from done until the next done or reset.
REQ-021 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-022 start asserted in the DONE cycle SHALL be ignored. start asserted in the cycle after done SHALL be accepted.
REQ-023 value=0 SHALL give negative=0 and digits all zero, with no negative zero.

Reset
REQ-024 Reset SHALL force state=IDLE, busy=0, done=0, digits=0, negative=0, error=0, and clear all internal registers.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion with no done pulse. After release, the block SHALL accept start on the first clock edge.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN, when defined, SHALL replace each leading zero digit with code 4'hF (blank). The least significant digit is never blanked.
REQ-027 Without LEADING_ZERO_BLANK_EN, every digit SHALL be plain BCD 0-9. Latency SHALL be identical with and without the macro.

Structure
REQ-028 Shared package calc_pkg SHALL hold the state encoding, the DIGITS default, and the constant BCD_BLANK=4'hF.
REQ-029 Sub-module bcd_digit_adjust SHALL implement the combinational add-3-if->=5 step for one digit. It SHALL be instantiated DIGITS+1 times.

Verification
REQ-030 value=998001, start pulse -> done 23 cycles later, digits=0x998001, negative=0, error=0.
REQ-031 value=-998001 -> digits=0x998001, negative=1, error=0. value=-1 -> digits=0x000001, negative=1.
REQ-032 value=-1048576 (most negative) -> error=1, digits=0. Separately, value=5 with ovf_in=1 -> error=1.
REQ-033 value=0 -> digits=0x000000, or 0xFFFFF0 with LEADING_ZERO_BLANK_EN. value=42 with LEADING_ZERO_BLANK_EN -> 0xFFFF42.
REQ-034 start pulsed at cycles 5 and 10 of a conversion -> exactly one done, with the first value's digits.
REQ-035 reset asserted at cycle 12 of a conversion -> busy=0 and no done pulse. A new start after release -> correct result at the nominal latency.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the result-to-BCD converter: FSM encoding,
// default digit count and the blank-digit code.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGITS_DEF = 6;

  // Code shown in place of a suppressed leading zero.
  localparam logic [3:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction: add 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adjust (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Pre-shift correction for one digit.
  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/result_bcd_converter.sv
// Signed ALU result to sign-magnitude BCD, serial double-dabble.
// One bit of the magnitude is shifted into the BCD accumulator per
// cycle. The accumulator has one spare top digit: anything landing
// there means the magnitude does not fit in DIGITS digits.
// Optional feature: define LEADING_ZERO_BLANK_EN to replace leading
// zero digits with the blank code (least significant digit is kept).
module result_bcd_converter
  import calc_pkg::*;
#(
  parameter int BITS   = 21,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BITS-1:0]       value,
  input  logic                  ovf_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  negative,
  output logic                  error
);

  localparam int AW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(BITS + 1);

  state_t              state, state_nx;
  logic [AW-1:0]       acc, adj;
  logic [BITS-1:0]     mag;
  logic [CW-1:0]       cnt;
  logic                neg_r, ovf_r;
  logic                fin;
  logic                err_c;
  logic [4*DIGITS-1:0] fmt;

  // Add-3 correction on every accumulator digit, including the spare one.
  for (genvar g = 0; g <= DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d (acc[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: SHIFT runs for BITS cycles, DONE for one.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == CW'(BITS - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Capture on start, then shift the corrected accumulator and magnitude.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      mag   <= '0;
      cnt   <= '0;
      neg_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          neg_r <= value[BITS-1];
          // Unsigned BITS-bit magnitude, so the most negative value is exact.
          mag   <= value[BITS-1] ? (~value + BITS'(1)) : value;
          ovf_r <= ovf_in;
          acc   <= '0;
          cnt   <= '0;
        end
        SHIFT: begin
          {acc, mag} <= {adj, mag} << 1;
          cnt        <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Final formatting: range/overflow check, zeroing on error, blanking.
  always_comb begin
    err_c = ovf_r | (acc[AW-1 -: 4] != 4'd0);
    fmt   = err_c ? '0 : acc[4*DIGITS-1:0];
`ifdef LEADING_ZERO_BLANK_EN
    begin : blank
      logic lead;
      lead = 1'b1;
      if (!err_c) begin
        for (int i = DIGITS - 1; i > 0; i--) begin
          if (lead && fmt[4*i +: 4] == 4'd0) fmt[4*i +: 4] = BCD_BLANK;
          else                               lead = 1'b0;
        end
      end
    end
`endif
  end

  // Output stage. fin marks the cycle after DONE; the accumulator and
  // captured flags are still intact then, because a new start only
  // overwrites them on the same edge that loads the outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fin      <= 1'b0;
      done     <= 1'b0;
      digits   <= '0;
      negative <= 1'b0;
      error    <= 1'b0;
    end else begin
      fin  <= (state == DONE);
      done <= fin;
      if (fin) begin
        digits   <= fmt;
        negative <= neg_r;
        error    <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter: the driver pushes the
// hand-computed result and due cycle for each accepted start, the
// monitor pops and compares whenever done is seen.
module tb_result_bcd_converter;

  localparam int BITS   = 21;
  localparam int DIGITS = 6;
  localparam int LAT    = BITS + 2;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [23:0] d;
    logic        neg;
    logic        err;
    int          cyc;
  } exp_t;

  logic                clock = 1'b0;
  logic                reset;
  logic                start;
  logic [BITS-1:0]     value;
  logic                ovf_in;
  logic                busy, done, negative, error;
  logic [4*DIGITS-1:0] digits;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  result_bcd_converter #(.BITS(BITS), .DIGITS(DIGITS)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .value    (value),
    .ovf_in   (ovf_in),
    .busy     (busy),
    .done     (done),
    .digits   (digits),
    .negative (negative),
    .error    (error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: digits=%h neg=%b err=%b at cycle %0d",
                 digits, negative, error, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if ({digits, negative, error} !== {e.d, e.neg, e.err}) begin
          errors++;
          $display("FAIL %s: got digits=%h neg=%b err=%b, want digits=%h neg=%b err=%b",
                   e.name, digits, negative, error, e.d, e.neg, e.err);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL %s_latency: done at cycle %0d, want %0d", e.name, cyc, e.cyc);
        end
      end
    end
  end

  // Drive start for one edge (caller is at a negedge); optionally expect a result.
  task automatic issue(input string name, input int v, input bit ovf, input bit push,
                       input logic [23:0] d, input bit neg, input bit err);
    exp_t e;
    value  = v[BITS-1:0];
    ovf_in = ovf;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    if (push) begin
      e.name = name; e.d = d; e.neg = neg; e.err = err; e.cyc = cyc + LAT;
      q.push_back(e);
    end
  endtask

  task automatic conv(input string name, input int v, input bit ovf,
                      input logic [23:0] d, input bit neg, input bit err);
    @(negedge clock);
    issue(name, v, ovf, 1'b1, d, neg, err);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (q.size() == 0 && !busy) break;
    end
    checks++;
    if (q.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_timeout: pending=%0d busy=%b, want pending=0 busy=0", name, q.size(), busy);
    end
  endtask

  task automatic check_clear(input string name);
    checks++;
    if ({busy, done, digits, negative, error} !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b digits=%h neg=%b err=%b, want all zero",
               name, busy, done, digits, negative, error);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; value = '0; ovf_in = 1'b0;
    repeat (3) @(negedge clock);
    check_clear("reset_state");
    reset = 1'b0;

    conv("pos_998001", 998001, 0, 24'h998001, 0, 0);
    wait_idle("pos_998001");
    conv("neg_998001", -998001, 0, 24'h998001, 1, 0);
    wait_idle("neg_998001");
    conv("neg_one", -1, 0, BL ? 24'hFFFFF1 : 24'h000001, 1, 0);
    wait_idle("neg_one");
    conv("most_neg", -1048576, 0, 24'h000000, 1, 1);
    wait_idle("most_neg");
    conv("ovf_in", 5, 1, 24'h000000, 0, 1);
    wait_idle("ovf_in");
    conv("zero", 0, 0, BL ? 24'hFFFFF0 : 24'h000000, 0, 0);
    wait_idle("zero");
    conv("v42", 42, 0, BL ? 24'hFFFF42 : 24'h000042, 0, 0);
    wait_idle("v42");
    conv("max_fit", 999999, 0, 24'h999999, 0, 0);
    wait_idle("max_fit");
    conv("neg_max_fit", -999999, 0, 24'h999999, 1, 0);
    wait_idle("neg_max_fit");
    conv("range_1e6", 1000000, 0, 24'h000000, 0, 1);
    wait_idle("range_1e6");
    conv("v123", 123, 0, BL ? 24'hFFF123 : 24'h000123, 0, 0);
    wait_idle("v123");

    // Starts while busy are dropped, not queued.
    conv("busy_first", 998001, 0, 24'h998001, 0, 0);
    repeat (4) @(negedge clock);
    issue("busy_5", 123, 0, 1'b0, 24'h0, 0, 0);
    repeat (4) @(negedge clock);
    issue("busy_10", 777, 0, 1'b0, 24'h0, 0, 0);
    wait_idle("busy_first");
    repeat (30) @(negedge clock);

    // Reset mid-conversion aborts; restart on the first edge after release.
    @(negedge clock);
    issue("aborted", 4321, 0, 1'b0, 24'h0, 0, 0);
    repeat (11) @(posedge clock);
    #1 reset = 1'b1;
    #1 check_clear("abort_reset");
    @(negedge clock);
    reset = 1'b0;
    issue("after_abort", 654321, 0, 1'b1, 24'h654321, 0, 0);
    wait_idle("after_abort");
    repeat (30) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
